// File: rtl/ysyx_23060332_lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states
// and the alignment rule used when deciding whether a request reaches memory.
package ysyx_23060332_lsu_pkg;

    localparam int LSU_ADDR_W = 32;
    localparam int LSU_DATA_W = 32;
    localparam int LSU_MASK_W = 8;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Unsupported encodings behave as word accesses.
    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic mis;
        case (funct3)
            LSU_B, LSU_BU: mis = 1'b0;
            LSU_H, LSU_HU: mis = off[0];
            default:       mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_23060332_lsu_align.sv
// Byte-lane steering: store data replication and write mask on the way out,
// load byte/half extraction with sign or zero extension on the way back.
module ysyx_23060332_lsu_align
    import ysyx_23060332_lsu_pkg::*;
(
    input  logic [2:0]            st_funct3,
    input  logic [1:0]            st_off,
    input  logic [LSU_DATA_W-1:0] st_wdata,
    output logic [3:0]            st_mask,
    output logic [LSU_DATA_W-1:0] st_lanes,
    input  logic [2:0]            ld_funct3,
    input  logic [1:0]            ld_off,
    input  logic [LSU_DATA_W-1:0] ld_rdata,
    output logic [LSU_DATA_W-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
    assign ld_half = ld_rdata[{ld_off[1], 4'b0000} +: 16];

    // Replicating the data across every lane lets the mask alone pick the target bytes.
    always_comb begin
        st_mask  = 4'b1111;
        st_lanes = st_wdata;
        case (st_funct3)
            LSU_B, LSU_BU: begin
                st_mask  = 4'b0001 << st_off;
                st_lanes = {4{st_wdata[7:0]}};
            end
            LSU_H, LSU_HU: begin
                st_mask  = 4'b0011 << st_off;
                st_lanes = {2{st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_data = ld_rdata;
        case (ld_funct3)
            LSU_B:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            LSU_BU:  ld_data = {24'h000000, ld_byte};
            LSU_H:   ld_data = {{16{ld_half[15]}}, ld_half};
            LSU_HU:  ld_data = {16'h0000, ld_half};
            LSU_W:   ld_data = ld_rdata;
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: one EXU request at a time, turned into a word-aligned memory
// request with byte mask, result returned to WBU after the memory response.
//
// state   | meaning
// IDLE    | accepting a new request from EXU
// REQ     | memory request presented, waiting for mem_req_ready
// WAIT    | request accepted, waiting for mem_rsp_valid
// RESP    | result (or misalign flag) presented to WBU
module ysyx_23060332_lsu
    import ysyx_23060332_lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DATA_W = LSU_DATA_W,
    parameter int MASK_W = LSU_MASK_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wen,
    input  logic [2:0]        in_funct3,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_misalign,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic        wen_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        accept;
    logic        in_misaligned;
    logic [3:0]  st_mask;
    logic [DATA_W-1:0] st_lanes;
    logic [DATA_W-1:0] ld_data;

    assign accept        = in_valid && in_ready;
    assign in_misaligned = lsu_misaligned(in_funct3, in_addr[1:0]);

    ysyx_23060332_lsu_align u_align (
        .st_funct3 (in_funct3),
        .st_off    (in_addr[1:0]),
        .st_wdata  (in_wdata),
        .st_mask   (st_mask),
        .st_lanes  (st_lanes),
        .ld_funct3 (funct3_q),
        .ld_off    (off_q),
        .ld_rdata  (mem_rdata),
        .ld_data   (ld_data)
    );

    always_comb begin
        state_d       = state_q;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        mem_req_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = in_misaligned ? ST_RESP : ST_REQ;
            end
            ST_REQ: begin
                // Gated by rst so a reset withdraws the request in the same cycle.
                mem_req_valid = !rst;
                if (mem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rsp_valid) state_d = ST_RESP;
            end
            ST_RESP: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wen_q        <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            mem_wen      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wmask    <= '0;
            out_rdata    <= '0;
            out_misalign <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wen_q        <= in_wen;
                funct3_q     <= in_funct3;
                off_q        <= in_addr[1:0];
                mem_wen      <= in_wen;
                mem_addr     <= {in_addr[ADDR_W-1:2], 2'b00};
                mem_wdata    <= st_lanes;
                mem_wmask    <= in_wen ? {{(MASK_W-4){1'b0}}, st_mask} : '0;
                out_rdata    <= '0;
                out_misalign <= in_misaligned;
            end
            if (state_q == ST_WAIT && mem_rsp_valid) begin
                out_rdata <= wen_q ? '0 : ld_data;
            end
            if (state_q == ST_RESP && out_ready) begin
                out_misalign <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Scoreboard bench for the LSU: stimulus pushes expected memory requests and
// results; independent memory and WBU processes pop and compare.
module tb_ysyx_23060332_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_wen;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata;
    logic        out_valid, out_ready, out_misalign;
    logic [31:0] out_rdata;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    ysyx_23060332_lsu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_misalign(out_misalign),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
        end
    endtask

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        misal;
        bit          cmp_rdata;
    } res_t;

    req_t        exp_req_q[$];
    res_t        exp_res_q[$];
    logic [31:0] mem_data_q[$];

    // 0 random, 1 always ready, 2 three/two-cycle stall, 3 never ready
    int mem_mode = 1;
    int out_mode = 1;
    int last_in_hs = 0;
    int last_out_hs = 0;
    logic [31:0] last_out_rdata = 32'h0;

    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rd);
        int sz = acc_size(f3);
        logic [31:0] v = rd >> (8 * int'(off));
        if (sz == 1) begin
            v = v & 32'h000000FF;
            if (f3 == 3'b000 && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz == 2) begin
            v = v & 32'h0000FFFF;
            if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    task automatic issue(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata);
        int sz = acc_size(f3);
        int off = int'(addr[1:0]);
        bit mis = (off % sz) != 0;
        bit done = 0;
        req_t r;
        res_t o;
        if (!mis) begin
            r.wen   = wen;
            r.addr  = {addr[31:2], 2'b00};
            r.wdata = 32'h0;
            for (int k = 0; k < 4; k++) r.wdata[8*k +: 8] = wdata[8*(k % sz) +: 8];
            r.wmask = wen ? 8'(((1 << sz) - 1) << off) : 8'h00;
            exp_req_q.push_back(r);
            mem_data_q.push_back(rdata);
        end
        o.misal     = mis;
        o.cmp_rdata = !mis;
        o.rdata     = (mis || wen) ? 32'h0 : ref_load(f3, addr[1:0], rdata);
        exp_res_q.push_back(o);
        in_valid  = 1'b1;
        in_wen    = wen;
        in_funct3 = f3;
        in_addr   = addr;
        in_wdata  = wdata;
        for (int i = 0; i < 500 && !done; i++) begin
            #1;
            if (in_ready) begin
                last_in_hs = cyc;
                @(posedge clk);
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) chk("in_handshake_timeout", 32'h0, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_res_q.size() == 0) break;
        end
        chk("drain_pending", 32'(exp_res_q.size()), 32'h0);
    endtask

    // Memory model: request checks, stability under stall, delayed responses
    initial begin
        bit waiting = 0;
        bit hold = 0;
        int dly = 0;
        int stall = 0;
        req_t h;
        req_t e;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rdata = $urandom;
            if (waiting) begin
                if (dly == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata = (mem_data_q.size() != 0) ? mem_data_q.pop_front() : $urandom;
                    waiting = 0;
                end else begin
                    dly--;
                end
            end else if (mem_mode == 0 && $urandom_range(0, 3) == 0) begin
                mem_rsp_valid = 1'b1;
            end
            case (mem_mode)
                0:       mem_req_ready = 1'($urandom_range(0, 1));
                1:       mem_req_ready = 1'b1;
                2:       mem_req_ready = (stall >= 3);
                default: mem_req_ready = 1'b0;
            endcase
            #1;
            if (rst) begin
                waiting = 0;
                hold = 0;
                stall = 0;
                continue;
            end
            if (mem_req_valid) begin
                chk("in_ready_during_req", 32'(in_ready), 32'h0);
                if (hold) begin
                    chk("req_addr_stable", mem_addr, h.addr);
                    chk("req_wdata_stable", mem_wdata, h.wdata);
                    chk("req_wmask_stable", 32'(mem_wmask), 32'(h.wmask));
                    chk("req_wen_stable", 32'(mem_wen), 32'(h.wen));
                end
                if (mem_req_ready) begin
                    if (exp_req_q.size() == 0) begin
                        chk("unexpected_mem_req", 32'h1, 32'h0);
                    end else begin
                        e = exp_req_q.pop_front();
                        chk("mem_addr", mem_addr, e.addr);
                        chk("mem_wmask", 32'(mem_wmask), 32'(e.wmask));
                        chk("mem_wen", 32'(mem_wen), 32'(e.wen));
                        if (e.wen) chk("mem_wdata", mem_wdata, e.wdata);
                    end
                    waiting = 1;
                    dly = (mem_mode == 0) ? int'($urandom_range(0, 3)) : 0;
                    hold = 0;
                    stall = 0;
                end else begin
                    hold = 1;
                    h.addr = mem_addr;
                    h.wdata = mem_wdata;
                    h.wmask = mem_wmask;
                    h.wen = mem_wen;
                    stall++;
                end
            end else begin
                hold = 0;
            end
        end
    end

    // WBU side: pops expected results on each out handshake
    initial begin
        bit hold = 0;
        int stall = 0;
        logic [31:0] h_rd;
        logic h_mis;
        res_t e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (out_mode)
                0:       out_ready = 1'($urandom_range(0, 1));
                1:       out_ready = 1'b1;
                2:       out_ready = (stall >= 2);
                default: out_ready = 1'b0;
            endcase
            #1;
            if (rst) begin
                hold = 0;
                stall = 0;
                continue;
            end
            if (out_valid) begin
                chk("in_ready_during_resp", 32'(in_ready), 32'h0);
                if (hold) begin
                    chk("out_rdata_stable", out_rdata, h_rd);
                    chk("out_misalign_stable", 32'(out_misalign), 32'(h_mis));
                end
                if (out_ready) begin
                    last_out_hs = cyc;
                    last_out_rdata = out_rdata;
                    if (exp_res_q.size() == 0) begin
                        chk("unexpected_out_valid", 32'h1, 32'h0);
                    end else begin
                        e = exp_res_q.pop_front();
                        chk("out_misalign", 32'(out_misalign), 32'(e.misal));
                        if (e.cmp_rdata) chk("out_rdata", out_rdata, e.rdata);
                    end
                    hold = 0;
                    stall = 0;
                end else begin
                    hold = 1;
                    h_rd = out_rdata;
                    h_mis = out_misalign;
                    stall++;
                end
            end else begin
                hold = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int gap;
        logic [2:0] f3_tab [8];
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        rst = 1'b1;
        in_valid = 1'b0;
        in_wen = 1'b0;
        in_funct3 = 3'b000;
        in_addr = 32'h0;
        in_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'h0);
        chk("rst_mem_wen", 32'(mem_wen), 32'h0);
        chk("rst_out_misalign", 32'(out_misalign), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wmask", 32'(mem_wmask), 32'h0);
        chk("rst_out_rdata", out_rdata, 32'h0);
        rst = 1'b0;

        mem_mode = 1;
        out_mode = 1;
        issue(1'b1, 3'b000, 32'h80000003, 32'h000000AB, $urandom);
        #1;
        chk("sb_req_latency", 32'(mem_req_valid), 32'h1);
        chk("sb_mem_addr", mem_addr, 32'h80000000);
        chk("sb_mem_wmask", 32'(mem_wmask), 32'h08);
        chk("sb_mem_wdata", mem_wdata, 32'hABABABAB);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            if (out_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
            #1;
        end
        chk("best_case_latency", 32'(lat), 32'd3);
        drain();

        issue(1'b0, 3'b000, 32'h80000001, 32'h0, 32'h0000F000);
        drain();
        chk("lb_result", last_out_rdata, 32'hFFFFFFF0);
        issue(1'b0, 3'b100, 32'h80000001, 32'h0, 32'h0000F000);
        drain();
        chk("lbu_result", last_out_rdata, 32'h000000F0);
        issue(1'b0, 3'b001, 32'h80000002, 32'h0, 32'h80011234);
        drain();
        chk("lh_result", last_out_rdata, 32'hFFFF8001);
        issue(1'b0, 3'b101, 32'h80000002, 32'h0, 32'h80011234);
        drain();
        chk("lhu_result", last_out_rdata, 32'h00008001);

        issue(1'b0, 3'b010, 32'h80000002, 32'h0, 32'h0);
        #1;
        chk("misalign_no_req", 32'(mem_req_valid), 32'h0);
        chk("misalign_out_valid", 32'(out_valid), 32'h1);
        chk("misalign_flag", 32'(out_misalign), 32'h1);
        drain();

        mem_mode = 2;
        out_mode = 2;
        issue(1'b0, 3'b010, 32'h80000004, 32'h0, $urandom);
        drain();

        mem_mode = 1;
        out_mode = 1;
        issue(1'b1, 3'b010, 32'h80000010, $urandom, $urandom);
        issue(1'b1, 3'b010, 32'h80000020, $urandom, $urandom);
        gap = last_in_hs - last_out_hs;
        chk("b2b_in_after_out", 32'(gap), 32'h1);
        #1;
        chk("b2b_wmask", 32'(mem_wmask), 32'h0F);
        drain();

        mem_mode = 3;
        issue(1'b0, 3'b010, 32'h80000040, 32'h0, $urandom);
        #1;
        chk("rst_test_req_valid", 32'(mem_req_valid), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        exp_req_q.delete();
        exp_res_q.delete();
        mem_data_q.delete();
        #1;
        chk("rst_drops_req", 32'(mem_req_valid), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);
        chk("post_rst_req_valid", 32'(mem_req_valid), 32'h0);
        chk("post_rst_out_valid", 32'(out_valid), 32'h0);

        mem_mode = 0;
        out_mode = 0;
        @(negedge clk);
        for (int n = 0; n < 200; n++) begin
            issue(1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 7)],
                  32'h80000000 | ($urandom & 32'h0000FFFF), $urandom, $urandom);
        end
        drain();
        chk("req_queue_empty", 32'(exp_req_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
